// File: rtl/cpu_bpu_if.sv
// cpu_bpu_if: fetch-side prediction bus and execute-side branch resolution for cpu_bpu
interface cpu_bpu_if #(parameter int PC_W = 16);
    logic            inst_valid;
    logic [PC_W-1:0] pc_now;
    logic [31:0]     instruction;
    logic            decompr_en;
    logic [31:0]     jmp_data;
    logic [4:0]      jmp_rs;
    logic            jmp_pred;
    logic            jmp_reg_en;
    logic            ras_hit;
    logic [PC_W-1:0] pc_jmp;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    modport master (
        output inst_valid, pc_now, instruction, decompr_en, jmp_data, upd_valid, upd_pc, upd_taken,
        input  jmp_rs, jmp_pred, jmp_reg_en, ras_hit, pc_jmp
    );
    modport slave (
        input  inst_valid, pc_now, instruction, decompr_en, jmp_data, upd_valid, upd_pc, upd_taken,
        output jmp_rs, jmp_pred, jmp_reg_en, ras_hit, pc_jmp
    );
endinterface

// File: rtl/cpu_bpu.sv
// cpu_bpu: dynamic branch predictor with 2-bit counter BHT and call/return address stack
module cpu_bpu #(
    parameter int PC_W      = 16,
    parameter int BHT_DEPTH = 64,
    parameter int RAS_DEPTH = 4
) (
    input logic       clk,
    input logic       rst_n,
    input logic       running,
    cpu_bpu_if.slave  bus
);
    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int RP_W  = $clog2(RAS_DEPTH);
    localparam logic [RP_W:0] CNT_MAX = (RP_W+1)'(RAS_DEPTH);
    localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    logic [31:0]     ins, pc32, imm_i, imm_b, imm_j;
    logic [4:0]      rd, rs1;
    logic            is_br, is_jal, is_jalr, is_call, is_ret, ras_ne, hit, do_push, do_pop;
    logic [IDX_W-1:0] rd_idx, up_idx;
    logic [BHT_DEPTH-1:0] bht_v;
    logic [1:0]      bht_c [BHT_DEPTH];
    logic [1:0]      cur_c, ctr_nxt;
    logic [PC_W-1:0] ras [RAS_DEPTH];
    logic [RP_W-1:0] ras_ptr, top_ptr;
    logic [RP_W:0]   ras_cnt;
    logic [PC_W-1:0] link, tgt_b, tgt_j, tgt_r;

    always_comb begin
        ins     = bus.instruction;
        pc32    = 32'(bus.pc_now);
        rd      = ins[11:7];
        rs1     = ins[19:15];
        imm_i   = {{20{ins[31]}}, ins[31:20]};
        imm_b   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_j   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        is_br   = ins[6:0] == OP_BR;
        is_jal  = ins[6:0] == OP_JAL;
        is_jalr = ins[6:0] == OP_JALR;
        is_call = (is_jal | is_jalr) & (rd == 5'd1 | rd == 5'd5);
        is_ret  = is_jalr & rd == 5'd0 & (rs1 == 5'd1 | rs1 == 5'd5);
        ras_ne  = ras_cnt != '0;
        hit     = is_ret & ras_ne;
        top_ptr = ras_ptr - RP_W'(1);
        link    = bus.pc_now + (bus.decompr_en ? PC_W'(2) : PC_W'(4));
        tgt_b   = PC_W'(pc32 + imm_b);
        tgt_j   = PC_W'(pc32 + imm_j);
        tgt_r   = PC_W'((bus.jmp_data + imm_i) & ~32'd1);
        rd_idx  = bus.pc_now[IDX_W:1];
        up_idx  = bus.upd_pc[IDX_W:1];
        do_push = running & bus.inst_valid & is_call;
        do_pop  = running & bus.inst_valid & hit;
        cur_c   = bht_c[up_idx];
        ctr_nxt = !bht_v[up_idx] ? (bus.upd_taken ? 2'd2 : 2'd1) :
                  bus.upd_taken ? (cur_c == 2'd3 ? cur_c : cur_c + 2'd1) :
                  (cur_c == 2'd0 ? cur_c : cur_c - 2'd1);
    end

    assign bus.jmp_rs     = rs1;
    assign bus.ras_hit    = hit;
    assign bus.jmp_reg_en = is_jalr & ~hit;
    assign bus.jmp_pred   = is_br ? (bht_v[rd_idx] ? bht_c[rd_idx][1] : imm_b[11]) : (is_jal | is_jalr);
    assign bus.pc_jmp     = is_br ? tgt_b : is_jal ? tgt_j :
                            is_jalr ? (hit ? ras[top_ptr] : tgt_r) : bus.pc_now;

    // counters are only meaningful once their valid bit is set, so only valids need reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bht_v <= '0;
        end else if (running && bus.upd_valid) begin
            bht_v[up_idx] <= 1'b1;
            bht_c[up_idx] <= ctr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (do_push && do_pop) begin
            ras[top_ptr] <= link;
        end else if (do_push) begin
            ras[ras_ptr] <= link;
            ras_ptr      <= ras_ptr + RP_W'(1);
            ras_cnt      <= ras_cnt == CNT_MAX ? ras_cnt : ras_cnt + 1'b1;
        end else if (do_pop) begin
            ras_ptr <= top_ptr;
            ras_cnt <= ras_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu_bpu.sv
// tb_cpu_bpu: scoreboard bench for cpu_bpu at default size and at PC_W=12/BHT_DEPTH=16
module tb_cpu_bpu;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk, rst_n, running;
    int total = 0, bad = 0;

    cpu_bpu_if #(.PC_W(16)) f0();
    cpu_bpu_if #(.PC_W(12)) f1();

    cpu_bpu #(.PC_W(16), .BHT_DEPTH(64), .RAS_DEPTH(4)) u0 (.clk(clk), .rst_n(rst_n), .running(running), .bus(f0));
    cpu_bpu #(.PC_W(12), .BHT_DEPTH(16), .RAS_DEPTH(4)) u1 (.clk(clk), .rst_n(rst_n), .running(running), .bus(f1));

    initial clk = 0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          sel;
        logic [39:0] v;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] enc_b(input logic [31:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'd0, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return {imm[11:0], rs1, 3'd0, rd, 7'b1100111};
    endfunction

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (rs,pred,reg_en,hit,pc_jmp)", tag, got, exp);
        end
    endtask

    task automatic inst0(input logic [15:0] pc, input logic [31:0] ins, input logic dec, input logic [31:0] jd);
        f0.pc_now = pc; f0.instruction = ins; f0.decompr_en = dec; f0.jmp_data = jd;
    endtask

    task automatic inst1(input logic [11:0] pc, input logic [31:0] ins);
        f1.pc_now = pc; f1.instruction = ins; f1.decompr_en = 1'b0; f1.jmp_data = '0;
    endtask

    task automatic expect_out(input string tag, input bit sel, input logic pred, input logic reg_en,
                              input logic hit, input logic [31:0] pc);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.v   = {sel ? f1.instruction[19:15] : f0.instruction[19:15], pred, reg_en, hit, pc};
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        logic [39:0] obs;
        @(negedge clk);
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = e.sel ? {f1.jmp_rs, f1.jmp_pred, f1.jmp_reg_en, f1.ras_hit, 32'(f1.pc_jmp)}
                        : {f0.jmp_rs, f0.jmp_pred, f0.jmp_reg_en, f0.ras_hit, 32'(f0.pc_jmp)};
            check(e.tag, obs, e.v);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        f0.inst_valid = 1; f0.upd_valid = 0; f0.upd_pc = '0; f0.upd_taken = 0;
        f1.inst_valid = 1; f1.upd_valid = 0; f1.upd_pc = '0; f1.upd_taken = 0;
        inst0(16'h0000, NOP, 0, 0);
        inst1(12'h000, NOP);
        rst_n = 0;
        running = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // static prediction with empty BHT
        inst0(16'h0040, enc_b(-8), 0, 0); expect_out("rst_bwd", 0, 1, 0, 0, 32'h0038); tick();
        inst0(16'h0040, enc_b(8), 0, 0);  expect_out("rst_fwd", 0, 0, 0, 0, 32'h0048); tick();

        // training; each read sees the counter before that cycle's update
        f0.upd_valid = 1; f0.upd_pc = 16'h0040; f0.upd_taken = 0;
        inst0(16'h0040, enc_b(-8), 0, 0);
        expect_out("nt1_old", 0, 1, 0, 0, 32'h0038); tick();
        expect_out("nt2_old", 0, 0, 0, 0, 32'h0038); tick();
        expect_out("nt3_old", 0, 0, 0, 0, 32'h0038); tick();
        f0.upd_valid = 0;
        expect_out("nt_done", 0, 0, 0, 0, 32'h0038); tick();
        f0.upd_valid = 1; f0.upd_taken = 1;
        expect_out("t1_old", 0, 0, 0, 0, 32'h0038); tick();
        expect_out("t2_old", 0, 0, 0, 0, 32'h0038); tick();
        f0.upd_valid = 0;
        expect_out("t_done", 0, 1, 0, 0, 32'h0038); tick();
        inst0(16'h0060, NOP, 0, 0); expect_out("nop", 0, 0, 0, 0, 32'h0060); tick();

        // call/return pairs, 32-bit and compressed link
        inst0(16'h0100, enc_j(1, 32'h40), 0, 0);           expect_out("call4", 0, 1, 0, 0, 32'h0140); tick();
        inst0(16'h0140, enc_jalr(0, 1, 0), 0, 32'h9999);   expect_out("ret4", 0, 1, 0, 1, 32'h0104); tick();
        inst0(16'h0100, enc_j(1, 32'h40), 1, 0);           expect_out("call2", 0, 1, 0, 0, 32'h0140); tick();
        inst0(16'h0140, enc_jalr(0, 1, 0), 0, 32'h9999);   expect_out("ret2", 0, 1, 0, 1, 32'h0102); tick();

        // five nested calls into a four-entry stack
        for (int i = 0; i < 5; i++) begin
            inst0(16'(16'h0200 + 16 * i), enc_j(1, 32'h10), 0, 0);
            expect_out($sformatf("ncall%0d", i), 0, 1, 0, 0, 32'(16'h0210 + 16 * i));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            inst0(16'h0300, enc_jalr(0, (i % 2) ? 5'd5 : 5'd1, 0), 0, 32'h9999);
            expect_out($sformatf("nret%0d", i), 0, 1, 0, 1, 32'(16'h0244 - 16 * i));
            tick();
        end
        inst0(16'h0300, enc_jalr(0, 1, 0), 0, 32'h9999); expect_out("nret_empty", 0, 1, 1, 0, 32'h9998); tick();

        // register-target call, then reset mid-sequence
        inst0(16'h0400, enc_jalr(1, 5, 4), 0, 32'h2003); expect_out("jalr_reg", 0, 1, 1, 0, 32'h2006); tick();
        inst0(16'h0410, enc_jalr(0, 1, 0), 0, 32'h1234); expect_out("ret_after", 0, 1, 0, 1, 32'h0404); tick();
        inst0(16'h0400, enc_jalr(1, 5, 4), 0, 32'h2003); expect_out("jalr_reg2", 0, 1, 1, 0, 32'h2006); tick();
        inst0(16'h0040, enc_b(8), 0, 0);                 expect_out("bht_fwd", 0, 1, 0, 0, 32'h0048); tick();
        rst_n = 0; f0.inst_valid = 0;
        expect_out("in_rst", 0, 1, 0, 0, 32'h0048); tick();
        rst_n = 1; f0.inst_valid = 1;
        expect_out("bht_cleared", 0, 0, 0, 0, 32'h0048); tick();
        running = 0;
        inst0(16'h0500, enc_j(1, 32'h20), 0, 0);         expect_out("frozen_call", 0, 1, 0, 0, 32'h0520); tick();
        running = 1;
        inst0(16'h0410, enc_jalr(0, 1, 0), 0, 32'h1234); expect_out("ras_cleared", 0, 1, 1, 0, 32'h1234); tick();

        // narrow instance: PC wrap and BHT aliasing
        inst0(16'h0000, NOP, 0, 0);
        inst1(12'hFFC, enc_j(0, 32'h8)); expect_out("wrap", 1, 1, 0, 0, 32'h004); tick();
        f1.upd_valid = 1; f1.upd_pc = 12'h022; f1.upd_taken = 0;
        inst1(12'h002, enc_b(-8)); expect_out("alias_old", 1, 1, 0, 0, 32'hFFA); tick();
        f1.upd_valid = 0;
        expect_out("alias", 1, 0, 0, 0, 32'hFFA); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_bpu.md
# cpu_bpu

Dynamic branch-prediction and target unit for the fetch stage: the parametrised successor to the static backward-taken predictor. It decodes the instruction paired with `pc_now` and drives `jmp_pred`, `jmp_reg_en`, `jmp_rs` and `pc_jmp` to the PC generator. Prediction uses a direct-mapped branch history table (BHT) of 2-bit saturating counters, trained by the execute stage, and a return address stack (RAS) for call/return JAL/JALR. PC width, BHT depth and RAS depth are parameters.

## Interface
- `PC_W`, 16, PC width in bits (≤32).
- `BHT_DEPTH`, 64, BHT entries; power of two, ≥2; `IDX_W = log2(BHT_DEPTH)`.
- `RAS_DEPTH`, 4, RAS entries; power of two, ≥2.
- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `running`  in  1  program-running flag; gates all state updates.
- `inst_valid`  in  1  `instruction`/`pc_now` pair is valid this cycle.
- `pc_now`  in  PC_W  PC of `instruction`.
- `instruction`  in  32  decompressed instruction at `pc_now`.
- `decompr_en`  in  1  current instruction was 16-bit; link address = `pc_now`+2, else +4.
- `jmp_data`  in  32  register value addressed by `jmp_rs`.
- `jmp_rs`  out  5  `instruction[19:15]`.
- `jmp_pred`  out  1  predict redirect.
- `jmp_reg_en`  out  1  target taken from register (JALR, no RAS hit).
- `ras_hit`  out  1  JALR target supplied by RAS.
- `pc_jmp`  out  PC_W  predicted target.
- `upd_valid`  in  1  execute-stage resolution of a conditional branch.
- `upd_pc`  in  PC_W  PC of the resolved branch.
- `upd_taken`  in  1  actual outcome.

## Operation
- Decode (combinational): opcode `instruction[6:0]`; immediates I/J/B as in RV32I; J and B immediates get bit 0 = 0; sign-extended to 32 bits.
- BHT entry = {valid, ctr[1:0]}; index = `pc[IDX_W:1]` (halfword aligned).
- BRANCH: `jmp_pred` = valid ? `ctr[1]` : `imm_b[11]` (static backward-taken fallback); `pc_jmp` = `pc_now` + imm_b; `jmp_reg_en`=0.
- JAL: `jmp_pred`=1; `pc_jmp` = `pc_now` + imm_j; `jmp_reg_en`=0.
- JALR: `jmp_pred`=1. Return = rd==x0 and rs1 ∈ {x1,x5}. If return and RAS non-empty: `ras_hit`=1, `jmp_reg_en`=0, `pc_jmp` = RAS top. Otherwise `jmp_reg_en`=1, `pc_jmp` = (`jmp_data` + imm_i) & ~1.
- Other opcodes: `jmp_pred`=`jmp_reg_en`=`ras_hit`=0, `pc_jmp`=`pc_now`.
- All 32-bit sums are truncated to the low PC_W bits; there is no overflow flag.
- Outputs are driven whenever `instruction` is present; state changes only when `running` & `inst_valid` (RAS) or `running` & `upd_valid` (BHT).
- Call = JAL/JALR with rd ∈ {x1,x5}: push link address.
- Pop on return with RAS non-empty.
- JALR that is both call and return: pop then push, so the top is replaced and the count is unchanged.
- RAS full on push: circular overwrite of oldest entry; count saturates at RAS_DEPTH.
- RAS empty on return: no pop, `ras_hit`=0.
- BHT update, counters saturating 0..3:
  - Valid entry: taken → ctr+1, not taken → ctr−1.
  - Invalid entry: set valid, ctr = taken ? 2 : 1.
- `flush_flag` is not an input. The RAS is not repaired on mispredict; a wrong RAS target is corrected by the normal execute flush.

## Timing
- Prediction outputs are combinational from `instruction`, `pc_now`, `jmp_data` and current state; latency 0.
- BHT and RAS writes commit on the `clk` edge and are visible the next cycle.
- BHT read and update to the same index in one cycle: the read returns the pre-update value (no bypass).
- Reset (`rst_n`=0 at `clk` edge, also mid-operation):
  - All BHT valid bits cleared; RAS count=0, pointer=0; RAS data undefined.
  - Outputs then follow decode with empty state, i.e. static prediction.
- `running`=0: state frozen; outputs still decode.

## Test plan
- Reset, then BRANCH at `pc_now`=0x0040 with imm_b=−8, BHT empty → `jmp_pred`=1, `pc_jmp`=0x0038. Same with imm_b=+8 → `jmp_pred`=0, `pc_jmp`=0x0048.
- Three `upd_valid` not-taken updates at 0x0040, then the backward branch at 0x0040 → `jmp_pred`=0. Two taken updates → `jmp_pred`=1. Same-cycle read/update of 0x0040 shows the old prediction.
- JAL rd=x1 at 0x0100, `decompr_en`=0, then JALR x0,0(x1) with `jmp_data`=0x9999 → `ras_hit`=1, `pc_jmp`=0x0104, `jmp_reg_en`=0. Repeat with `decompr_en`=1 → `pc_jmp`=0x0102.
- Five nested calls with RAS_DEPTH=4, then five returns → first four return 4th..1st… i.e. calls 5,4,3,2 link addresses in order; fifth return has `ras_hit`=0, `pc_jmp`=(`jmp_data`+imm)&~1.
- JALR x1,4(x5) with `jmp_data`=0x2003 and RAS empty → `jmp_reg_en`=1, `pc_jmp`=0x2006 (0x2007 with bit 0 cleared), then one RAS entry pushed. Assert `rst_n`=0 one cycle mid-sequence → BHT and RAS cleared, static prediction resumes.
- PC_W=12, BHT_DEPTH=16: JAL at 0xFFC with imm_j=+8 → `pc_jmp`=0x004 (wrap). `upd_pc` 0x002 and 0x022 alias to the same entry.
